// File: rtl/power_up_sequencer.sv
// Staged reset release after first_reset completes: one stage every STAGE_DELAY
// cycles, ready after a final wait, full re-sequence on fault.
module power_up_sequencer #(
  parameter int NUM_STAGES   = 3,
  parameter int STAGE_DELAY  = 16,
  parameter int RESTART_HOLD = 4,
  parameter int CNT_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_rst,
  input  logic                  init_done,
  input  logic                  fault,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  ready,
  output logic [3:0]            restart_cnt,
  output logic [2:0]            seq_state
);

  // state   | meaning
  // IDLE    | all stages in reset, waiting for init_done
  // HOLD    | counting down to the first release
  // RELEASE | releasing stages one per STAGE_DELAY, then final wait
  // RUN     | all stages released, ready high
  // FAULT   | all stages re-held for RESTART_HOLD cycles
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HOLD    = 3'd1;
  localparam logic [2:0] S_RELEASE = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_FAULT   = 3'd4;

  localparam int IDX_W = $clog2(NUM_STAGES + 1);
  localparam logic [CNT_W-1:0] STAGE_TC = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(RESTART_HOLD - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES);

  logic [2:0]            state_q, state_d;
  logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic                  ready_q, ready_d;
  logic [3:0]            restart_cnt_q, restart_cnt_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  always_comb begin
    state_d       = state_q;
    stage_rst_d   = stage_rst_q;
    ready_d       = ready_q;
    restart_cnt_d = restart_cnt_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;

    if (init_rst) begin
      state_d     = S_IDLE;
      stage_rst_d = '1;
      ready_d     = 1'b0;
      cnt_d       = '0;
      idx_d       = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          stage_rst_d = '1;
          ready_d     = 1'b0;
          cnt_d       = '0;
          idx_d       = '0;
          if (init_done) state_d = S_HOLD;
        end
        S_HOLD, S_RELEASE: begin
          if (fault && state_q == S_RELEASE) begin
            state_d     = S_FAULT;
            stage_rst_d = '1;
            ready_d     = 1'b0;
            cnt_d       = '0;
            idx_d       = '0;
            if (restart_cnt_q != 4'hF) restart_cnt_d = restart_cnt_q + 4'd1;
          end else if (fault) begin
            cnt_d = '0;
          end else if (cnt_q == STAGE_TC) begin
            cnt_d = '0;
            // idx reaching NUM_STAGES means the post-release wait has elapsed
            if (idx_q == LAST_IDX) begin
              state_d = S_RUN;
              ready_d = 1'b1;
            end else begin
              state_d     = S_RELEASE;
              stage_rst_d = stage_rst_q & ~(NUM_STAGES'(1) << idx_q);
              idx_d       = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (fault) begin
            state_d     = S_FAULT;
            stage_rst_d = '1;
            ready_d     = 1'b0;
            cnt_d       = '0;
            idx_d       = '0;
            if (restart_cnt_q != 4'hF) restart_cnt_d = restart_cnt_q + 4'd1;
          end
        end
        S_FAULT: begin
          stage_rst_d = '1;
          ready_d     = 1'b0;
          if (fault) begin
            cnt_d = '0;
          end else if (cnt_q == HOLD_TC) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d     = S_IDLE;
          stage_rst_d = '1;
          ready_d     = 1'b0;
          cnt_d       = '0;
          idx_d       = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      stage_rst_q   <= '1;
      ready_q       <= 1'b0;
      restart_cnt_q <= 4'd0;
      cnt_q         <= '0;
      idx_q         <= '0;
    end else begin
      state_q       <= state_d;
      stage_rst_q   <= stage_rst_d;
      ready_q       <= ready_d;
      restart_cnt_q <= restart_cnt_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
    end
  end

  assign stage_rst   = stage_rst_q;
  assign ready       = ready_q;
  assign restart_cnt = restart_cnt_q;
  assign seq_state   = state_q;

endmodule

// File: tb/tb_power_up_sequencer.sv
// Scenario-based bench for power_up_sequencer; expectations come from the
// release-time formulas (stage k at t+1+(k+1)*D, ready at t+1+(N+1)*D).
module tb_power_up_sequencer;

  localparam int N = 3;
  localparam int D = 16;
  localparam int H = 4;

  logic         clk = 1'b0;
  logic         rst, init_rst, init_done, fault;
  logic [N-1:0] stage_rst;
  logic         ready;
  logic [3:0]   restart_cnt;
  logic [2:0]   seq_state;

  int vecs = 0;
  int errs = 0;
  int exp_rc = 0;

  power_up_sequencer #(.NUM_STAGES(N), .STAGE_DELAY(D), .RESTART_HOLD(H), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .init_rst(init_rst), .init_done(init_done), .fault(fault),
    .stage_rst(stage_rst), .ready(ready), .restart_cnt(restart_cnt), .seq_state(seq_state)
  );

  always #5 clk = ~clk;

  // Reference model: n = cycles since the accepting edge t (value seen after edge t+n-1).
  function automatic logic [N-1:0] m_stage(int n);
    logic [N-1:0] v;
    int r;
    r = 0;
    for (int k = 0; k < N; k++) if (n >= 1 + (k + 1) * D) r++;
    v = '1;
    v = v << r;
    return v;
  endfunction

  function automatic logic m_ready(int n);
    return n >= 1 + (N + 1) * D;
  endfunction

  function automatic logic [2:0] m_state(int n);
    if (n >= 1 + (N + 1) * D) return 3'd3;
    if (n >= 1 + D) return 3'd2;
    return 3'd1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; init_rst = 1'b0; init_done = 1'b1; fault = 1'b1;
    repeat (3) step();
    fault = 1'b0;
    vecs++; if (stage_rst !== 3'b111) begin errs++; $display("FAIL reset_stage_rst got %b exp 111", stage_rst); end
    vecs++; if (ready !== 1'b0) begin errs++; $display("FAIL reset_ready got %b exp 0", ready); end
    vecs++; if (restart_cnt !== 4'd0) begin errs++; $display("FAIL reset_restart_cnt got %0d exp 0", restart_cnt); end
    vecs++; if (seq_state !== 3'd0) begin errs++; $display("FAIL reset_state got %0d exp 0", seq_state); end
  endtask

  task automatic test_power_up();
    rst = 1'b1; init_rst = 1'b1; init_done = 1'b0;
    repeat (10) step();
    vecs++; if (seq_state !== 3'd0 || stage_rst !== 3'b111) begin
      errs++; $display("FAIL init_rst_hold got state %0d rst %b exp 0 111", seq_state, stage_rst); end
    init_rst = 1'b0; init_done = 1'b1;
    step();
    for (int n = 1; n <= 70; n++) begin
      vecs++; if (stage_rst !== m_stage(n)) begin errs++; $display("FAIL pu_stage n=%0d got %b exp %b", n, stage_rst, m_stage(n)); end
      vecs++; if (ready !== m_ready(n)) begin errs++; $display("FAIL pu_ready n=%0d got %b exp %b", n, ready, m_ready(n)); end
      vecs++; if (seq_state !== m_state(n)) begin errs++; $display("FAIL pu_state n=%0d got %0d exp %0d", n, seq_state, m_state(n)); end
      if (n < 70) step();
    end
  endtask

  task automatic test_fault();
    logic [2:0] es;
    fault = 1'b1; step(); fault = 1'b0;
    exp_rc = (exp_rc < 15) ? exp_rc + 1 : 15;
    vecs++; if (stage_rst !== 3'b111 || ready !== 1'b0) begin
      errs++; $display("FAIL fault_outputs got %b/%b exp 111/0", stage_rst, ready); end
    vecs++; if (restart_cnt !== 4'(exp_rc)) begin errs++; $display("FAIL fault_rc got %0d exp %0d", restart_cnt, exp_rc); end
    for (int n = 1; n <= 5 + 65; n++) begin
      if (n <= H) es = 3'd4;
      else if (n == H + 1) es = 3'd0;
      else es = m_state(n - H - 1);
      vecs++; if (seq_state !== es) begin errs++; $display("FAIL fault_state n=%0d got %0d exp %0d", n, seq_state, es); end
      if (n > H + 1) begin
        vecs++; if (stage_rst !== m_stage(n - H - 1) || ready !== m_ready(n - H - 1)) begin
          errs++; $display("FAIL fault_reseq n=%0d got %b/%b exp %b/%b", n, stage_rst, ready,
                           m_stage(n - H - 1), m_ready(n - H - 1)); end
      end
      if (n < 70) step();
    end
  endtask

  task automatic test_fault_retrigger();
    logic [2:0] es;
    fault = 1'b1; step(); fault = 1'b0;
    exp_rc = (exp_rc < 15) ? exp_rc + 1 : 15;
    step();
    fault = 1'b1; step(); fault = 1'b0;
    // second pulse at n=2 restarts the hold: FAULT through n=2+H, IDLE at n=3+H
    for (int n = 3; n <= H + 4; n++) begin
      es = (n <= H + 2) ? 3'd4 : (n == H + 3) ? 3'd0 : 3'd1;
      vecs++; if (seq_state !== es) begin errs++; $display("FAIL retrig_state n=%0d got %0d exp %0d", n, seq_state, es); end
      step();
    end
    vecs++; if (restart_cnt !== 4'(exp_rc)) begin errs++; $display("FAIL retrig_rc got %0d exp %0d", restart_cnt, exp_rc); end
  endtask

  task automatic test_random_fault();
    int k;
    for (int it = 0; it < 6; it++) begin
      init_rst = 1'b1; step(); init_rst = 1'b0; init_done = 1'b1;
      step();
      k = $urandom_range(D + 1, (N + 1) * D + 12);
      for (int n = 1; n <= k; n++) begin
        vecs++; if (stage_rst !== m_stage(n) || ready !== m_ready(n) || seq_state !== m_state(n)) begin
          errs++; $display("FAIL rnd_seq n=%0d got %b/%b/%0d exp %b/%b/%0d", n, stage_rst, ready, seq_state,
                           m_stage(n), m_ready(n), m_state(n)); end
        if (n < k) begin init_done = 1'($urandom_range(0, 1)); step(); end
      end
      init_done = 1'b1; fault = 1'b1; step(); fault = 1'b0;
      exp_rc = (exp_rc < 15) ? exp_rc + 1 : 15;
      vecs++; if (seq_state !== 3'd4 || stage_rst !== 3'b111 || ready !== 1'b0 || restart_cnt !== 4'(exp_rc)) begin
        errs++; $display("FAIL rnd_fault k=%0d got %0d/%b/%b/%0d exp 4/111/0/%0d", k, seq_state, stage_rst,
                         ready, restart_cnt, exp_rc); end
    end
  endtask

  task automatic test_hold_fault();
    int j;
    for (int it = 0; it < 4; it++) begin
      init_rst = 1'b1; step(); init_rst = 1'b0; init_done = 1'b1;
      step();
      j = $urandom_range(1, D);
      for (int n = 1; n <= j + D + 1; n++) begin
        vecs++; if (stage_rst !== ((n <= j + D) ? 3'b111 : 3'b110) || seq_state === 3'd4) begin
          errs++; $display("FAIL hold_fault j=%0d n=%0d got %b/%0d", j, n, stage_rst, seq_state); end
        fault = (n == j);
        step();
        fault = 1'b0;
      end
      vecs++; if (restart_cnt !== 4'(exp_rc)) begin errs++; $display("FAIL hold_fault_rc got %0d exp %0d", restart_cnt, exp_rc); end
    end
  endtask

  task automatic test_init_rst_mid();
    init_rst = 1'b1; step(); init_rst = 1'b0; init_done = 1'b1;
    vecs++; if (seq_state !== 3'd0) begin errs++; $display("FAIL mid_idle got %0d exp 0", seq_state); end
    step();
    for (int n = 1; n <= 40; n++) begin
      vecs++; if (stage_rst !== m_stage(n)) begin errs++; $display("FAIL mid_stage n=%0d got %b exp %b", n, stage_rst, m_stage(n)); end
      if (n < 40) step();
    end
    init_rst = 1'b1; step(); init_rst = 1'b0;
    vecs++; if (stage_rst !== 3'b111 || ready !== 1'b0 || seq_state !== 3'd0) begin
      errs++; $display("FAIL mid_abort got %b/%b/%0d exp 111/0/0", stage_rst, ready, seq_state); end
    vecs++; if (restart_cnt !== 4'(exp_rc)) begin errs++; $display("FAIL mid_rc got %0d exp %0d", restart_cnt, exp_rc); end
  endtask

  task automatic test_simultaneous();
    int w = 0;
    while (ready !== 1'b1 && w < 300) begin step(); w++; end
    vecs++; if (ready !== 1'b1) begin errs++; $display("FAIL simul_wait_ready got %b exp 1", ready); end
    init_rst = 1'b1; fault = 1'b1; step(); init_rst = 1'b0; fault = 1'b0;
    vecs++; if (seq_state !== 3'd0 || stage_rst !== 3'b111 || ready !== 1'b0) begin
      errs++; $display("FAIL simul_state got %0d/%b/%b exp 0/111/0", seq_state, stage_rst, ready); end
    vecs++; if (restart_cnt !== 4'(exp_rc)) begin errs++; $display("FAIL simul_rc got %0d exp %0d", restart_cnt, exp_rc); end
  endtask

  task automatic test_saturation();
    int w;
    for (int p = 0; p < 17; p++) begin
      w = 0;
      while (ready !== 1'b1 && w < 300) begin step(); w++; end
      vecs++; if (ready !== 1'b1) begin errs++; $display("FAIL sat_wait_ready p=%0d got %b exp 1", p, ready); end
      repeat ($urandom_range(0, 3)) step();
      fault = 1'b1; step(); fault = 1'b0;
      exp_rc = (exp_rc < 15) ? exp_rc + 1 : 15;
      vecs++; if (restart_cnt !== 4'(exp_rc) || seq_state !== 3'd4) begin
        errs++; $display("FAIL sat_rc p=%0d got %0d/%0d exp %0d/4", p, restart_cnt, seq_state, exp_rc); end
    end
  endtask

  task automatic test_sync_reset();
    init_rst = 1'b1; step(); init_rst = 1'b0; init_done = 1'b1;
    step();
    repeat (34) step();
    vecs++; if (stage_rst !== m_stage(35)) begin errs++; $display("FAIL srst_pre got %b exp %b", stage_rst, m_stage(35)); end
    rst = 1'b0; init_done = 1'b0; step(); rst = 1'b1;
    exp_rc = 0;
    vecs++; if (stage_rst !== 3'b111 || ready !== 1'b0 || restart_cnt !== 4'd0 || seq_state !== 3'd0) begin
      errs++; $display("FAIL srst_values got %b/%b/%0d/%0d exp 111/0/0/0", stage_rst, ready, restart_cnt, seq_state); end
    for (int n = 0; n < 60; n++) begin
      step();
      vecs++; if (stage_rst !== 3'b111 || seq_state !== 3'd0) begin
        errs++; $display("FAIL srst_no_release n=%0d got %b/%0d exp 111/0", n, stage_rst, seq_state); end
    end
  endtask

  initial begin
    rst = 1'b0; init_rst = 1'b0; init_done = 1'b0; fault = 1'b0;
    test_reset();
    test_power_up();
    test_fault();
    test_fault_retrigger();
    test_random_fault();
    test_hold_fault();
    test_init_rst_mid();
    test_simultaneous();
    test_saturation();
    test_sync_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/power_up_sequencer.md
Name: power_up_sequencer

Overview:
- Consumes the rst/done handshake produced by the first_reset power-on generator.
- Once initialisation is complete, releases the downstream domains of the static-screen SoC (sync generator, pixel fetch, Wishbone slave) one stage at a time, with a fixed spacing between stages.
- Asserts ready after the last stage is released.
- On a fault request, re-applies all stage resets and sequences again.

Parameters:
- NUM_STAGES, 3: number of downstream reset stages released in order 0..NUM_STAGES-1 (1..8).
- STAGE_DELAY, 16: clock cycles between successive releases (>=1, <=2^CNT_W).
- RESTART_HOLD, 4: cycles all stage resets are held after a fault (>=1, <=2^CNT_W).
- CNT_W, 8: width of the internal delay counter.

Ports:
- clk  in  1  system clock
- rst  in  1  global reset; synchronous, active-low
- init_rst  in  1  active-high reset from the first_reset generator
- init_done  in  1  high once first_reset has completed; level signal
- fault  in  1  active-high re-sequence request, sampled each cycle
- stage_rst  out  NUM_STAGES  active-high reset to each downstream stage
- ready  out  1  high when all stages are released
- restart_cnt  out  4  number of fault-triggered restarts, saturating at 15
- seq_state  out  3  encoded FSM state, for debug only

Behaviour:
- All outputs are registered.
- Reset (rst==0 at a clk edge):
  - state=IDLE, stage_rst=all ones, ready=0, restart_cnt=0, counter=0, stage index=0.
  - rst has priority over every other input.
- Input priority below rst: init_rst > fault > normal sequencing.
- init_rst==1 in any state: next cycle state=IDLE, stage_rst=all ones, ready=0. restart_cnt is unchanged.
- States and encodings: IDLE=0, HOLD=1, RELEASE=2, RUN=3, FAULT=4.
- IDLE:
  - stage_rst all ones, ready=0.
  - When init_done==1 and init_rst==0 at edge t: state=HOLD at t+1, counter=0, stage index=0.
  - fault is ignored in IDLE.
- HOLD and RELEASE:
  - counter increments every cycle.
  - When counter==STAGE_DELAY-1, clear stage_rst[index] (visible next cycle), counter=0, index+1.
  - HOLD moves to RELEASE with the first release.
  - Release timing relative to t:
    - stage_rst[k] falls at t+1+(k+1)*STAGE_DELAY.
    - ready rises at t+1+(NUM_STAGES+1)*STAGE_DELAY, entering RUN. The final STAGE_DELAY wait is after the last release.
  - With the defaults: stage0 at t+17, stage1 at t+33, stage2 at t+49, ready at t+65.
  - Released stages stay released until init_rst, fault or rst.
- fault in HOLD: counter restarts at 0. It does not enter FAULT and does not increment restart_cnt.
- fault in RELEASE or RUN at edge f:
  - At f+1: state=FAULT, stage_rst=all ones, ready=0, counter=0, restart_cnt+1 (held at 15 once reached).
- FAULT:
  - Lasts RESTART_HOLD cycles, then returns to IDLE.
  - fault re-asserted during FAULT restarts the counter and does not increment restart_cnt.
  - If init_done is still 1, IDLE moves to HOLD on the following edge.
- init_done falling while in HOLD, RELEASE or RUN is ignored; only init_rst restarts the sequence.
- NUM_STAGES==1: a single release, then ready STAGE_DELAY cycles later.
- stage_rst bits never go 1→0 out of order; at most one bit changes per cycle during sequencing.

Test Plan:
- Power-up: rst=0 for 3 cycles, then rst=1, init_rst=1 for 10 cycles, then init_rst=0 with init_done=1 at edge t → stage_rst=3'b111 until t+16; 3'b110 at t+17, 3'b100 at t+33, 3'b000 at t+49; ready=1 at t+65; seq_state=3.
- Fault in RUN: pulse fault 1 cycle at edge f → at f+1 stage_rst=3'b111, ready=0, restart_cnt=1, seq_state=4; IDLE at f+5, HOLD at f+6; ready re-rises at f+6+64.
- Saturation: 17 fault pulses, each after ready → restart_cnt=15 after the 15th and stays 15.
- init_rst mid-sequence: assert init_rst at t+40 (stage_rst=3'b100) → at t+41 stage_rst=3'b111, ready=0, seq_state=0; restart_cnt is unchanged.
- Simultaneous init_rst and fault in RUN: assert both for one cycle → state IDLE, not FAULT, and restart_cnt is unchanged.
- Sync reset mid-RELEASE: rst=0 for one cycle at t+35 → next cycle all outputs at reset values; no release occurs while init_done==0 afterwards.
